mult_tiled_seq: RTL and testbench

Parametrised, sequential unsigned multiplier that reuses a single 2x2-bit tile multiplier over all tile pairs of two WIDTH-bit operands, accumulating shifted partial products into a 2*WIDTH-bit result. Successor to the fixed 4-bit four-tile combinational multipliers: it trades latency for area, scales to any even width, and adds valid/ready handshakes on input and output. Sits between operand sources and result consumers in the multiplier evaluation datapath; the tile cell is swappable for any generated 2x2 cell with the same port list.

---
 rtl/mult_pkg.sv | 17 +
 rtl/tile_mult2x2.sv | 11 +
 rtl/mult_tiled_seq.sv | 104 ++++++++++
 tb/tb_mult_tiled_seq.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the tiled sequential multiplier: tile width, control
// states and the tiles-per-operand helper.
package mult_pkg;

  localparam int TILE_W = 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic int nt_of(input int width);
    return width / TILE_W;
  endfunction

endpackage

// File: rtl/tile_mult2x2.sv
// Combinational 2x2-bit unsigned multiplier tile; any generated cell with the
// same ports can stand in for it.
module tile_mult2x2 (
  input  logic [1:0] A,
  input  logic [1:0] B,
  output logic [3:0] P
);

  assign P = {2'b00, A} * {2'b00, B};

endmodule

// File: rtl/mult_tiled_seq.sv
// Sequential unsigned multiplier: one 2x2 tile visits every tile pair of A and B,
// accumulating shifted partial products, with valid/ready on both sides.
module mult_tiled_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] P
);

  localparam int NT = nt_of(WIDTH);
  localparam int IW = (NT > 1) ? $clog2(NT) : 1;
  localparam int PW = 2 * WIDTH;
  localparam logic [IW-1:0] LAST = IW'(NT - 1);

  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
    $error("mult_tiled_seq: WIDTH must be even and >= 4");
  end

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [PW-1:0]    acc, sum, p_reg;
  logic [IW-1:0]    i, j;
  logic [1:0]       a_t, b_t;
  logic [3:0]       tile_p;
  logic             last_pair;

  assign a_t       = a_reg[TILE_W*i +: TILE_W];
  assign b_t       = b_reg[TILE_W*j +: TILE_W];
  assign last_pair = (i == LAST) && (j == LAST);

  tile_mult2x2 u_tile (
    .A(a_t),
    .B(b_t),
    .P(tile_p)
  );

  // Tile pair (i, j) carries weight 2^(2*(i+j)); the largest shift is 2*WIDTH-4.
  assign sum = acc + (PW'(tile_p) << (TILE_W * (int'(i) + int'(j))));

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last_pair) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      p_reg <= '0;
      i     <= '0;
      j     <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            acc <= '0;
            i   <= '0;
            j   <= '0;
          end
        end
        RUN: begin
          acc <= sum;
          if (j == LAST) begin
            j <= '0;
            i <= last_pair ? '0 : i + 1'b1;
          end else begin
            j <= j + 1'b1;
          end
          if (last_pair) p_reg <= sum;
        end
        default: ;
      endcase
    end
  end

  // NOTE: operand registers carry no reset; they are always loaded before use.
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      a_reg <= A;
      b_reg <= B;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign P         = p_reg;

endmodule

// File: tb/tb_mult_tiled_seq.sv
// Bench for mult_tiled_seq at WIDTH 4, 8 and 16: vector table, hand sequences for
// backpressure and mid-run reset, exhaustive 4-bit sweep and a 16-bit random run.
module tb_mult_tiled_seq;

  localparam int NT2 [3] = '{4, 16, 64};

  typedef struct {
    int          k;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] p;
  } vec_t;

  logic        clk = 1'b0;
  logic [2:0]  rst_a, iv, ordy;
  wire  [2:0]  ir, ov;
  logic [15:0] a_arr [3];
  logic [15:0] b_arr [3];
  logic [7:0]  p_w4;
  logic [15:0] p_w8;
  logic [31:0] p_w16;
  logic [31:0] p_arr [3];

  logic [31:0] sb [3][$];
  logic [2:0]  ov_prev = '0, hs_prev = '0;
  logic [31:0] p_prev [3];
  int          last_acc [3];
  int          cyc = 0;
  int          n_cmp = 0, n_bad = 0;
  vec_t        vecs [12];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mult_tiled_seq #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst(rst_a[0]), .in_valid(iv[0]), .in_ready(ir[0]),
    .A(a_arr[0][3:0]), .B(b_arr[0][3:0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .P(p_w4)
  );

  mult_tiled_seq #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst_a[1]), .in_valid(iv[1]), .in_ready(ir[1]),
    .A(a_arr[1][7:0]), .B(b_arr[1][7:0]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .P(p_w8)
  );

  mult_tiled_seq #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst(rst_a[2]), .in_valid(iv[2]), .in_ready(ir[2]),
    .A(a_arr[2]), .B(b_arr[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .P(p_w16)
  );

  always_comb begin
    p_arr[0] = 32'(p_w4);
    p_arr[1] = 32'(p_w8);
    p_arr[2] = p_w16;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: latency on out_valid rise, product at handshake,
  // P held steady while stalled, in_ready back the cycle after a handshake.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst_a[k]) begin
        sb[k].delete();
        ov_prev[k] <= 1'b0;
        hs_prev[k] <= 1'b0;
      end else begin
        if (hs_prev[k]) begin
          check($sformatf("in_ready_after_hs_k%0d", k), 32'(ir[k]), 32'd1);
          check($sformatf("valid_drop_k%0d", k), 32'(ov[k]), 32'd0);
        end
        if (iv[k] && ir[k]) last_acc[k] <= cyc + 1;
        if (ov[k] && !ov_prev[k]) begin
          if (sb[k].size() == 0)
            check($sformatf("spurious_valid_k%0d", k), 32'(ov[k]), 32'd0);
          else
            check($sformatf("latency_k%0d", k), 32'(cyc - last_acc[k]), 32'(NT2[k]));
        end
        if (ov[k] && ov_prev[k])
          check($sformatf("p_stable_k%0d", k), p_arr[k], p_prev[k]);
        if (ov[k] && ordy[k] && sb[k].size() != 0) begin
          check($sformatf("product_k%0d", k), p_arr[k], sb[k][0]);
          void'(sb[k].pop_front());
        end
        hs_prev[k] <= ov[k] && ordy[k];
        ov_prev[k] <= ov[k];
        p_prev[k]  <= p_arr[k];
      end
    end
  end

  // mode 0: out_ready high; 1: random out_ready; 2: stall 5 DONE cycles.
  task automatic op(input int k, input logic [15:0] a, input logic [15:0] b,
                    input logic [31:0] exp, input int mode);
    int n;
    int hold;
    @(posedge clk); #1;
    ordy[k]  = (mode == 2) ? 1'b0 : 1'b1;
    a_arr[k] = a;
    b_arr[k] = b;
    iv[k]    = 1'b1;
    sb[k].push_back(exp);
    n = 0;
    while (!ir[k] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) check($sformatf("accept_timeout_k%0d", k), 32'(n), 32'd0);
    @(posedge clk); #1;
    iv[k] = 1'b0;
    n = 0;
    hold = 0;
    while (sb[k].size() != 0 && n < 2000) begin
      iv[k]    = 1'($urandom);
      a_arr[k] = 16'($urandom);
      b_arr[k] = 16'($urandom);
      if (mode == 1) begin
        ordy[k] = 1'($urandom);
      end else if (mode == 2) begin
        if (ov[k]) hold++;
        ordy[k] = (hold > 5);
      end
      @(posedge clk); #1;
      n++;
    end
    if (n >= 2000) begin
      check($sformatf("result_timeout_k%0d", k), 32'(n), 32'd0);
      sb[k].delete();
    end
    iv[k]   = 1'b0;
    ordy[k] = 1'b1;
  endtask

  initial begin
    logic [31:0] ra, rb;
    vecs[0]  = '{1, 16'h00FF, 16'h00FF, 32'h0000_FE01};
    vecs[1]  = '{1, 16'h0000, 16'h00A5, 32'h0000_0000};
    vecs[2]  = '{1, 16'h0080, 16'h0002, 32'h0000_0100};
    vecs[3]  = '{1, 16'h0012, 16'h0034, 32'h0000_03A8};
    vecs[4]  = '{1, 16'h0055, 16'h00AA, 32'h0000_3872};
    vecs[5]  = '{1, 16'h0001, 16'h00FF, 32'h0000_00FF};
    vecs[6]  = '{0, 16'h000D, 16'h000B, 32'h0000_008F};
    vecs[7]  = '{0, 16'h000F, 16'h000F, 32'h0000_00E1};
    vecs[8]  = '{0, 16'h0000, 16'h0007, 32'h0000_0000};
    vecs[9]  = '{2, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001};
    vecs[10] = '{2, 16'h8000, 16'h0002, 32'h0001_0000};
    vecs[11] = '{2, 16'h1234, 16'h0010, 32'h0001_2340};

    rst_a = 3'b111;
    iv    = 3'b000;
    ordy  = 3'b111;
    for (int k = 0; k < 3; k++) begin
      a_arr[k] = '0;
      b_arr[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst_a = 3'b000;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset_out_valid_k%0d", k), 32'(ov[k]), 32'd0);
      check($sformatf("reset_p_k%0d", k), p_arr[k], 32'd0);
      check($sformatf("reset_in_ready_k%0d", k), 32'(ir[k]), 32'd1);
    end

    for (int v = 0; v < 12; v++)
      op(vecs[v].k, vecs[v].a, vecs[v].b, vecs[v].p, 0);

    op(1, 16'h00C3, 16'h005A, 32'h0000_448E, 2);

    // Abort an 8-bit operation part-way through RUN; it must never surface.
    @(posedge clk); #1;
    a_arr[1] = 16'h0077;
    b_arr[1] = 16'h0099;
    iv[1]    = 1'b1;
    @(posedge clk); #1;
    iv[1] = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst_a[1] = 1'b1;
    @(posedge clk); #1;
    rst_a[1] = 1'b0;
    @(negedge clk);
    check("midrun_reset_out_valid", 32'(ov[1]), 32'd0);
    check("midrun_reset_p", p_arr[1], 32'd0);
    check("midrun_reset_in_ready", 32'(ir[1]), 32'd1);
    repeat (20) @(negedge clk);
    op(1, 16'h0012, 16'h0034, 32'h0000_03A8, 0);

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        op(0, 16'(a), 16'(b), 32'(a * b), 0);

    for (int n = 0; n < 20; n++) begin
      ra = 32'($urandom_range(255));
      rb = 32'($urandom_range(255));
      op(1, ra[15:0], rb[15:0], ra * rb, 1);
    end

    for (int n = 0; n < 100; n++) begin
      ra = 32'($urandom_range(65535));
      rb = 32'($urandom_range(65535));
      op(2, ra[15:0], rb[15:0], ra * rb, 1);
    end

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
